// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: captures register file read data, resolves RAW hazards,
// detects load-use stalls, and presents one registered operand bundle over valid/ready.
// Optional macro OPERAND_FWD_EN: when undefined, forwarding is replaced by a full interlock.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rs3,
    input  logic [2:0]        in_use,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_is_load,
    input  logic [OP_W-1:0]   in_ctrl,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [DATA_W-1:0] rf_data3,
    input  logic              em_valid,
    input  logic              em_reg_write,
    input  logic              em_is_load,
    input  logic [REG_AW-1:0] em_rd,
    input  logic [DATA_W-1:0] em_data,
    input  logic              mw_valid,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [DATA_W-1:0] mw_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_op3,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_is_load,
    output logic [OP_W-1:0]   out_ctrl,
    output logic              hazard_stall,
    output logic [15:0]       stall_count
);

    logic [REG_AW-1:0] rs [3];
    logic [DATA_W-1:0] rf [3];
    logic [DATA_W-1:0] op_sel [3];
    logic [2:0]        em_hit;
    logic [2:0]        mw_hit;
    logic              accept;

    always_comb begin
        rs[0] = in_rs1;
        rs[1] = in_rs2;
        rs[2] = in_rs3;
        rf[0] = rf_data1;
        rf[1] = rf_data2;
        rf[2] = rf_data3;
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            em_hit[i] = in_use[i] && (rs[i] != '0) && em_valid && em_reg_write && (em_rd == rs[i]);
            mw_hit[i] = in_use[i] && (rs[i] != '0) && mw_valid && mw_reg_write && (mw_rd == rs[i]);
        end
    end

`ifdef OPERAND_FWD_EN
    // EX/MEM is the younger producer, so it outranks MEM/WB on the same register.
    always_comb begin
        hazard_stall = in_valid && (em_hit != 3'b000) && em_is_load;
        for (int i = 0; i < 3; i++) begin
            op_sel[i] = rf[i];
            if (rs[i] == '0)
                op_sel[i] = '0;
            else if (em_hit[i])
                op_sel[i] = em_data;
            else if (mw_hit[i])
                op_sel[i] = mw_data;
        end
    end
`else
    // Without forwarding the producer results are never looked at; only their tags interlock.
    logic unused_fwd;
    assign unused_fwd = ^{em_data, mw_data, em_is_load};

    always_comb begin
        hazard_stall = in_valid && ((em_hit | mw_hit) != 3'b000);
        for (int i = 0; i < 3; i++) begin
            op_sel[i] = (rs[i] == '0) ? '0 : rf[i];
        end
    end
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard_stall && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_op1       <= '0;
            out_op2       <= '0;
            out_op3       <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_is_load   <= 1'b0;
            out_ctrl      <= '0;
            stall_count   <= '0;
        end else begin
            if (hazard_stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;

            // Flush kills both the held entry and the offered one; data fields are left as-is.
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid     <= 1'b1;
                out_op1       <= op_sel[0];
                out_op2       <= op_sel[1];
                out_op3       <= op_sel[2];
                out_rd        <= in_rd;
                out_reg_write <= in_reg_write;
                out_is_load   <= in_is_load;
                out_ctrl      <= in_ctrl;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized plus directed bench for id_ex_operand_stage against a source-rule reference model.
// Follows OPERAND_FWD_EN the same way the design does.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rs3;
    logic [2:0]  in_use;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_is_load;
    logic [5:0]  in_ctrl;
    logic [31:0] rf_data1, rf_data2, rf_data3;
    logic        em_valid, em_reg_write, em_is_load;
    logic [4:0]  em_rd;
    logic [31:0] em_data;
    logic        mw_valid, mw_reg_write;
    logic [4:0]  mw_rd;
    logic [31:0] mw_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_op3;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_is_load;
    logic [5:0]  out_ctrl;
    logic        hazard_stall;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference state of the output register
    logic        m_valid;
    logic [31:0] m_op [3];
    logic [4:0]  m_rd;
    logic        m_rw, m_ld;
    logic [5:0]  m_ctrl;
    logic [15:0] m_cnt;
    logic [15:0] cnt0;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_use(in_use),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .rf_data3(rf_data3),
        .em_valid(em_valid), .em_reg_write(em_reg_write), .em_is_load(em_is_load),
        .em_rd(em_rd), .em_data(em_data),
        .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_data(mw_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
        .out_ctrl(out_ctrl), .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic producer_writes(input logic v, input logic rw, input logic [4:0] prd,
                                             input logic [4:0] src, input logic used);
        return used && (src != 5'd0) && v && rw && (prd == src);
    endfunction

    task automatic clear_inputs();
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_use = '0;
        in_rd = '0; in_reg_write = 1'b0; in_is_load = 1'b0; in_ctrl = '0;
        rf_data1 = '0; rf_data2 = '0; rf_data3 = '0;
        em_valid = 1'b0; em_reg_write = 1'b0; em_is_load = 1'b0; em_rd = '0; em_data = '0;
        mw_valid = 1'b0; mw_reg_write = 1'b0; mw_rd = '0; mw_data = '0;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        logic [4:0]  rs [3];
        logic [31:0] rf [3];
        logic [31:0] nop [3];
        logic        stall, rdy, acc, e, m;
        rs = '{in_rs1, in_rs2, in_rs3};
        rf = '{rf_data1, rf_data2, rf_data3};
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = producer_writes(em_valid, em_reg_write, em_rd, rs[i], in_use[i]);
            m = producer_writes(mw_valid, mw_reg_write, mw_rd, rs[i], in_use[i]);
`ifdef OPERAND_FWD_EN
            if (e && em_is_load) stall = in_valid;
            if (rs[i] == 5'd0)    nop[i] = 32'd0;
            else if (e)           nop[i] = em_data;
            else if (m)           nop[i] = mw_data;
            else                  nop[i] = rf[i];
`else
            if (e || m) stall = in_valid;
            nop[i] = (rs[i] == 5'd0) ? 32'd0 : rf[i];
`endif
        end
        rdy = (!m_valid || out_ready) && !stall && !flush;
        acc = in_valid && rdy;
        #1;
        check("hazard_stall", hazard_stall, stall);
        check("in_ready", in_ready, rdy);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_op = '{32'd0, 32'd0, 32'd0};
            m_rd = 0; m_rw = 0; m_ld = 0; m_ctrl = 0; m_cnt = 0;
        end else begin
            if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_op = nop; m_rd = in_rd;
                m_rw = in_reg_write; m_ld = in_is_load; m_ctrl = in_ctrl;
            end else if (m_valid && out_ready) m_valid = 0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_op1", out_op1, m_op[0]);
        check("out_op2", out_op2, m_op[1]);
        check("out_op3", out_op3, m_op[2]);
        check("out_rd", out_rd, m_rd);
        check("out_reg_write", out_reg_write, m_rw);
        check("out_is_load", out_is_load, m_ld);
        check("out_ctrl", out_ctrl, m_ctrl);
        check("stall_count", stall_count, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        m_valid = 0; m_op = '{32'd0, 32'd0, 32'd0};
        m_rd = 0; m_rw = 0; m_ld = 0; m_ctrl = 0; m_cnt = 0;

        // Reset held two cycles with an instruction offered
        rst = 1'b1; in_valid = 1'b1; in_rs1 = 5'd3; in_use = 3'b111; rf_data1 = 32'h1234;
        @(negedge clk);
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_op1", out_op1, 32'd0);
        check("rst_stall_count", stall_count, 16'd0);

        // Unused source never stalls and takes register file data
        clear_inputs();
        in_valid = 1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rs3 = 5'd7; in_use = 3'b011;
        em_valid = 1; em_reg_write = 1; em_is_load = 1; em_rd = 5'd7;
        rf_data3 = 32'hCAFE_0003;
        #1 check("unused_nostall", hazard_stall, 1'b0);
        step();
        check("unused_op3", out_op3, 32'hCAFE_0003);

        // Backpressure then flush
        clear_inputs();
        in_valid = 1; in_rd = 5'd9; in_reg_write = 1; in_ctrl = 6'h2A;
        step();
        out_ready = 0; in_ctrl = 6'h15;
        repeat (3) begin
            #1 check("bp_in_ready", in_ready, 1'b0);
            step();
            check("bp_ctrl_frozen", out_ctrl, 6'h2A);
        end
        flush = 1; in_ctrl = 6'h3F;
        step();
        check("flush_valid", out_valid, 1'b0);
        flush = 0; in_valid = 0; out_ready = 1;
        step();
        check("flush_dropped_valid", out_valid, 1'b0);
        check("flush_dropped_ctrl", out_ctrl, 6'h2A);

`ifdef OPERAND_FWD_EN
        // Forward priority on rs1
        clear_inputs();
        in_valid = 1; in_rs1 = 5'd5; in_use = 3'b001; rf_data1 = 32'h1111;
        em_valid = 1; em_reg_write = 1; em_rd = 5'd5; em_data = 32'hAAAA;
        mw_valid = 1; mw_reg_write = 1; mw_rd = 5'd5; mw_data = 32'hBBBB;
        step();
        check("fwd_em", out_op1, 32'hAAAA);
        em_valid = 0;
        step();
        check("fwd_mw", out_op1, 32'hBBBB);
        mw_valid = 0;
        step();
        check("fwd_rf", out_op1, 32'h1111);
        in_rs1 = 5'd0; em_valid = 1; em_rd = 5'd0;
        step();
        check("fwd_r0", out_op1, 32'd0);

        // Load-use: one stall, then forwarded from MEM/WB
        clear_inputs();
        in_valid = 1; in_rs2 = 5'd7; in_use = 3'b010;
        em_valid = 1; em_reg_write = 1; em_is_load = 1; em_rd = 5'd7;
        cnt0 = m_cnt;
        #1 check("lu_stall", hazard_stall, 1'b1);
        check("lu_in_ready", in_ready, 1'b0);
        step();
        check("lu_count", stall_count, cnt0 + 16'd1);
        em_valid = 0; mw_valid = 1; mw_reg_write = 1; mw_rd = 5'd7; mw_data = 32'h55;
        #1 check("lu_released", hazard_stall, 1'b0);
        step();
        check("lu_op2", out_op2, 32'h55);
`else
        // Interlock: EX/MEM then MEM/WB each cost a stall, operand comes from the register file
        clear_inputs();
        in_valid = 1; in_rs1 = 5'd5; in_use = 3'b001; rf_data1 = 32'h1111;
        em_valid = 1; em_reg_write = 1; em_rd = 5'd5; em_data = 32'hAAAA;
        cnt0 = m_cnt;
        #1 check("il_em_stall", hazard_stall, 1'b1);
        step();
        em_valid = 0; mw_valid = 1; mw_reg_write = 1; mw_rd = 5'd5; mw_data = 32'hBBBB;
        #1 check("il_mw_stall", hazard_stall, 1'b1);
        step();
        check("il_count", stall_count, cnt0 + 16'd2);
        mw_valid = 0;
        #1 check("il_clear", hazard_stall, 1'b0);
        step();
        check("il_valid", out_valid, 1'b1);
        check("il_op1", out_op1, 32'h1111);
`endif

        // Randomized traffic over a small register window so matches are frequent
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            in_rs1       = 5'($urandom_range(0, 3));
            in_rs2       = 5'($urandom_range(0, 3));
            in_rs3       = 5'($urandom_range(0, 3));
            in_use       = 3'($urandom);
            in_rd        = 5'($urandom);
            in_reg_write = 1'($urandom);
            in_is_load   = 1'($urandom);
            in_ctrl      = 6'($urandom);
            rf_data1     = $urandom;
            rf_data2     = $urandom;
            rf_data3     = $urandom;
            em_valid     = 1'($urandom);
            em_reg_write = 1'($urandom);
            em_is_load   = 1'($urandom);
            em_rd        = 5'($urandom_range(0, 3));
            em_data      = $urandom;
            mw_valid     = 1'($urandom);
            mw_reg_write = 1'($urandom);
            mw_rd        = 5'($urandom_range(0, 3));
            mw_data      = $urandom;
            step();
        end

        // Stall counter saturation under a permanent load-use hazard
        clear_inputs();
        in_valid = 1; in_rs1 = 5'd3; in_use = 3'b001;
        em_valid = 1; em_reg_write = 1; em_is_load = 1; em_rd = 5'd3;
        step();
        repeat (65540) @(posedge clk);
        @(negedge clk);
        m_cnt = 16'hFFFF;
        step();
        check("sat_count", stall_count, 16'hFFFF);
        rst = 1;
        step();
        check("sat_cleared", stall_count, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
